gpr_sb: RTL and testbench



---
 rtl/gpr_sb_pkg.sv | 21 ++
 rtl/gpr_scoreboard.sv | 55 +++++
 rtl/gpr_sb.sv | 111 +++++++++++
 tb/tb_gpr_sb.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/gpr_sb_pkg.sv
// Shared CPU definitions for the GPR file: default geometry, signalling polarities
// and the hardwired-zero register index.
package gpr_sb_pkg;

    localparam int unsigned GprDataW  = 32;
    localparam int unsigned GprAddrW  = 5;
    localparam int unsigned GprRegNum = 32;

    localparam logic EnActive  = 1'b0;  // write/issue strobes are active low
    localparam logic RstActive = 1'b0;  // reset_ asserts low

    localparam int unsigned ZeroRegIdx = 0;

    // True when an address names a real, writable register.
    function automatic logic addr_ok(input int unsigned addr,
                                     input int unsigned reg_num,
                                     input int unsigned zero_reg);
        return (addr < reg_num) && !((zero_reg != 0) && (addr == ZeroRegIdx));
    endfunction

endpackage

// File: rtl/gpr_scoreboard.sv
// Per-register busy bits with flush > clear < set priority and a registered busy count.
module gpr_scoreboard
    import gpr_sb_pkg::*;
#(
    parameter int unsigned AddrW  = GprAddrW,
    parameter int unsigned RegNum = GprRegNum
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              clr0_i,
    input  logic [AddrW-1:0]  clr0_addr_i,
    input  logic              clr1_i,
    input  logic [AddrW-1:0]  clr1_addr_i,
    input  logic              set_i,
    input  logic [AddrW-1:0]  set_addr_i,
    input  logic              flush_i,
    output logic [RegNum-1:0] busy_o,
    output logic [AddrW:0]    busy_cnt_o
);

    logic [RegNum-1:0] busy_q, busy_d;
    logic [AddrW:0]    cnt_q, cnt_d;

    always_comb begin
        busy_d = busy_q;
        cnt_d  = '0;
        if (flush_i) begin
            busy_d = '0;
        end else begin
            for (int i = 0; i < RegNum; i++) begin
                if (clr0_i && (clr0_addr_i == AddrW'(i))) busy_d[i] = 1'b0;
                if (clr1_i && (clr1_addr_i == AddrW'(i))) busy_d[i] = 1'b0;
                // A new producer supersedes a same-cycle writeback.
                if (set_i && (set_addr_i == AddrW'(i))) busy_d[i] = 1'b1;
            end
        end
        for (int i = 0; i < RegNum; i++) begin
            cnt_d = cnt_d + (AddrW + 1)'(busy_d[i]);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            busy_q <= '0;
            cnt_q  <= '0;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
        end
    end

    assign busy_o     = busy_q;
    assign busy_cnt_o = cnt_q;

endmodule

// File: rtl/gpr_sb.sv
// General-purpose register file with two write ports, NRD bypassed read ports
// and a pending-write scoreboard.
module gpr_sb
    import gpr_sb_pkg::*;
#(
    parameter int unsigned DATA_W   = GprDataW,
    parameter int unsigned ADDR_W   = GprAddrW,
    parameter int unsigned REG_NUM  = GprRegNum,
    parameter int unsigned NRD      = 2,
    parameter int unsigned ZERO_REG = 1
) (
    input  logic                  clk,
    input  logic                  reset_,
    input  logic [NRD*ADDR_W-1:0] RdAddr,
    output logic [NRD*DATA_W-1:0] RdData,
    output logic [NRD-1:0]        RdBusy,
    input  logic                  WE0_,
    input  logic [ADDR_W-1:0]     WrAddr0,
    input  logic [DATA_W-1:0]     WrData0,
    input  logic                  WE1_,
    input  logic [ADDR_W-1:0]     WrAddr1,
    input  logic [DATA_W-1:0]     WrData1,
    input  logic                  Issue_,
    input  logic [ADDR_W-1:0]     IssueAddr,
    input  logic                  Flush,
    output logic [ADDR_W:0]       BusyCnt
);

    logic              running;
    logic              we0_ok, we1_ok, iss_ok;
    logic [REG_NUM-1:0] busy;
    logic [DATA_W-1:0] regs_q [REG_NUM];
    logic [DATA_W-1:0] regs_d [REG_NUM];

    // Gating on reset_ keeps bypassed reads at zero while reset is held.
    assign running = (reset_ != RstActive);
    assign we0_ok  = running && (WE0_ == EnActive) && addr_ok(32'(WrAddr0), REG_NUM, ZERO_REG);
    assign we1_ok  = running && (WE1_ == EnActive) && addr_ok(32'(WrAddr1), REG_NUM, ZERO_REG);
    assign iss_ok  = running && (Issue_ == EnActive)
                     && addr_ok(32'(IssueAddr), REG_NUM, ZERO_REG);

    always_comb begin
        regs_d = regs_q;
        for (int i = 0; i < REG_NUM; i++) begin
            if (we0_ok && (WrAddr0 == ADDR_W'(i))) begin
                regs_d[i] = WrData0;
            end else if (we1_ok && (WrAddr1 == ADDR_W'(i))) begin
                regs_d[i] = WrData1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_) begin
        if (reset_ == RstActive) begin
            for (int i = 0; i < REG_NUM; i++) regs_q[i] <= '0;
        end else begin
            for (int i = 0; i < REG_NUM; i++) regs_q[i] <= regs_d[i];
        end
    end

    gpr_scoreboard #(
        .AddrW  (ADDR_W),
        .RegNum (REG_NUM)
    ) u_scoreboard (
        .clk_i       (clk),
        .rst_ni      (reset_),
        .clr0_i      (we0_ok),
        .clr0_addr_i (WrAddr0),
        .clr1_i      (we1_ok),
        .clr1_addr_i (WrAddr1),
        .set_i       (iss_ok),
        .set_addr_i  (IssueAddr),
        .flush_i     (Flush),
        .busy_o      (busy),
        .busy_cnt_o  (BusyCnt)
    );

    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] arr_data, data;
        logic              arr_busy, ok, hit0, hit1;

        assign addr = RdAddr[k*ADDR_W +: ADDR_W];
        assign ok   = addr_ok(32'(addr), REG_NUM, ZERO_REG);
        assign hit0 = we0_ok && (WrAddr0 == addr);
        assign hit1 = we1_ok && (WrAddr1 == addr);

        always_comb begin
            arr_data = '0;
            arr_busy = 1'b0;
            for (int i = 0; i < REG_NUM; i++) begin
                if (addr == ADDR_W'(i)) begin
                    arr_data = regs_q[i];
                    arr_busy = busy[i];
                end
            end
        end

        always_comb begin
            if (!ok)       data = '0;
            else if (hit0) data = WrData0;
            else if (hit1) data = WrData1;
            else           data = arr_data;
        end

        assign RdData[k*DATA_W +: DATA_W] = data;
        // A value arriving this cycle is forwarded, so the operand is not busy.
        assign RdBusy[k] = ok && arr_busy && !hit0 && !hit1;
    end

endmodule

// File: tb/tb_gpr_sb.sv
// Directed self-checking bench for gpr_sb (24 registers, so addresses 24..31 are out of range).
module tb_gpr_sb;

    localparam int unsigned DW = 32;
    localparam int unsigned AW = 5;
    localparam int unsigned RN = 24;
    localparam int unsigned NR = 2;

    logic             clk = 1'b0;
    logic             reset_;
    logic [NR*AW-1:0] RdAddr;
    logic [NR*DW-1:0] RdData;
    logic [NR-1:0]    RdBusy;
    logic             WE0_, WE1_, Issue_, Flush;
    logic [AW-1:0]    WrAddr0, WrAddr1, IssueAddr;
    logic [DW-1:0]    WrData0, WrData1;
    logic [AW:0]      BusyCnt;

    int checks = 0;
    int errors = 0;

    gpr_sb #(
        .DATA_W   (DW),
        .ADDR_W   (AW),
        .REG_NUM  (RN),
        .NRD      (NR),
        .ZERO_REG (1)
    ) dut (
        .clk       (clk),
        .reset_    (reset_),
        .RdAddr    (RdAddr),
        .RdData    (RdData),
        .RdBusy    (RdBusy),
        .WE0_      (WE0_),
        .WrAddr0   (WrAddr0),
        .WrData0   (WrData0),
        .WE1_      (WE1_),
        .WrAddr1   (WrAddr1),
        .WrData1   (WrData1),
        .Issue_    (Issue_),
        .IssueAddr (IssueAddr),
        .Flush     (Flush),
        .BusyCnt   (BusyCnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        WE0_ = 1'b1; WE1_ = 1'b1; Issue_ = 1'b1; Flush = 1'b0;
        WrAddr0 = '0; WrAddr1 = '0; IssueAddr = '0; WrData0 = '0; WrData1 = '0;
    endtask

    task automatic rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
        RdAddr = {a1, a0};
    endtask

    // Advance past the next rising edge and return the inputs to idle.
    task automatic tick();
        @(posedge clk);
        #1;
        idle();
        #1;
    endtask

    initial begin
        reset_ = 1'b0;
        idle();
        rd(5'd3, 5'd10);
        #2;
        chk("reset_data", 64'(RdData), 64'h0);
        chk("reset_cnt", 64'(BusyCnt), 64'h0);
        chk("reset_busy", 64'(RdBusy), 64'h0);
        @(negedge clk);
        reset_ = 1'b1;
        tick();

        // Write r3 and issue r10, then reset mid-run
        WE0_ = 1'b0; WrAddr0 = 5'd3; WrData0 = 32'h1234;
        Issue_ = 1'b0; IssueAddr = 5'd10;
        tick();
        chk("r3_written", 64'(RdData[31:0]), 64'h1234);
        chk("r10_busy", 64'(RdBusy), 64'b10);
        chk("cnt_one", 64'(BusyCnt), 64'd1);
        reset_ = 1'b0;
        #1;
        chk("midrst_data", 64'(RdData), 64'h0);
        chk("midrst_cnt", 64'(BusyCnt), 64'h0);
        chk("midrst_busy", 64'(RdBusy), 64'h0);
        @(negedge clk);
        reset_ = 1'b1;
        tick();
        chk("r3_after_rst", 64'(RdData[31:0]), 64'h0);

        // Same-cycle bypass on port 0
        rd(5'd5, 5'd5);
        WE0_ = 1'b0; WrAddr0 = 5'd5; WrData0 = 32'hDEADBEEF;
        #1;
        chk("bypass_comb", 64'(RdData), {32'hDEADBEEF, 32'hDEADBEEF});
        tick();
        chk("bypass_array", 64'(RdData[31:0]), 64'hDEADBEEF);

        // Collision: port 0 wins
        rd(5'd7, 5'd7);
        WE0_ = 1'b0; WrAddr0 = 5'd7; WrData0 = 32'hAAAA;
        WE1_ = 1'b0; WrAddr1 = 5'd7; WrData1 = 32'h5555;
        #1;
        chk("collide_comb", 64'(RdData), {32'hAAAA, 32'hAAAA});
        tick();
        chk("collide_array", 64'(RdData), {32'hAAAA, 32'hAAAA});

        // Port 1 alone
        rd(5'd8, 5'd7);
        WE1_ = 1'b0; WrAddr1 = 5'd8; WrData1 = 32'h5555;
        tick();
        chk("port1_write", 64'(RdData), {32'hAAAA, 32'h5555});

        // Scoreboard issue then writeback on port 1
        rd(5'd5, 5'd9);
        Issue_ = 1'b0; IssueAddr = 5'd9;
        tick();
        chk("r9_busy", 64'(RdBusy), 64'b10);
        chk("r9_cnt", 64'(BusyCnt), 64'd1);
        WE1_ = 1'b0; WrAddr1 = 5'd9; WrData1 = 32'h42;
        #1;
        chk("r9_fwd_busy", 64'(RdBusy), 64'b00);
        chk("r9_fwd_data", 64'(RdData[63:32]), 64'h42);
        chk("r9_cnt_hold", 64'(BusyCnt), 64'd1);
        tick();
        chk("r9_cnt_clr", 64'(BusyCnt), 64'd0);
        chk("r9_data", 64'(RdData[63:32]), 64'h42);

        // Set wins over same-cycle write, then flush discards an issue
        rd(5'd4, 5'd6);
        Issue_ = 1'b0; IssueAddr = 5'd4;
        WE0_ = 1'b0; WrAddr0 = 5'd4; WrData0 = 32'h77;
        tick();
        chk("setwins_busy", 64'(RdBusy), 64'b01);
        chk("setwins_cnt", 64'(BusyCnt), 64'd1);
        chk("setwins_data", 64'(RdData[31:0]), 64'h77);
        Flush = 1'b1; Issue_ = 1'b0; IssueAddr = 5'd6;
        WE1_ = 1'b0; WrAddr1 = 5'd12; WrData1 = 32'h99;
        #1;
        chk("flush_comb_busy", 64'(RdBusy), 64'b01);
        tick();
        chk("flush_busy", 64'(RdBusy), 64'b00);
        chk("flush_cnt", 64'(BusyCnt), 64'd0);
        rd(5'd4, 5'd12);
        #1;
        chk("flush_keeps", 64'(RdData), {32'h99, 32'h77});

        // Zero register: write and issue ignored
        Issue_ = 1'b0; IssueAddr = 5'd13;
        tick();
        rd(5'd0, 5'd13);
        WE0_ = 1'b0; WrAddr0 = 5'd0; WrData0 = 32'hFFFF;
        Issue_ = 1'b0; IssueAddr = 5'd0;
        #1;
        chk("r0_comb", 64'(RdData[31:0]), 64'h0);
        tick();
        chk("r0_data", 64'(RdData[31:0]), 64'h0);
        chk("r0_busy", 64'(RdBusy), 64'b10);
        chk("r0_cnt", 64'(BusyCnt), 64'd1);

        // Out of range (>= 24): write/issue ignored, reads 0 and not busy
        rd(5'd30, 5'd30);
        WE1_ = 1'b0; WrAddr1 = 5'd30; WrData1 = 32'h1111;
        Issue_ = 1'b0; IssueAddr = 5'd30;
        #1;
        chk("oor_comb", 64'(RdData), 64'h0);
        tick();
        chk("oor_data", 64'(RdData), 64'h0);
        chk("oor_busy", 64'(RdBusy), 64'b00);
        chk("oor_cnt", 64'(BusyCnt), 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
